// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - sequential signed multiply / restoring divide execute unit
// Multiply completes one edge after start, divide after 32 iterations; data_resultRDY pulses in DONE.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DONE} state_t;

   state_t      state, state_next;
   logic [31:0] op_a, op_b, abs_b;
   logic        sign;
   logic [63:0] pair;
   logic [5:0]  count;

   logic        start;
   logic [31:0] abs_a_in, abs_b_in;
   logic [63:0] product;
   logic        mul_ovf;
   logic [63:0] shifted, pair_next;
   logic [32:0] trial;
   logic        div_zero, div_ovf;
   logic [31:0] quotient;

   assign start    = ctrl_MULT | ctrl_DIV;
   assign abs_a_in = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
   assign abs_b_in = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

   // Low 64 bits of the sign-extended product equal the signed 32x32 product
   assign product  = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
   assign mul_ovf  = (product[63:31] != {33{product[31]}});

   assign shifted   = {pair[62:0], 1'b0};
   assign trial     = {1'b0, shifted[63:32]} - {1'b0, abs_b};
   assign pair_next = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};
   assign quotient  = sign ? (~pair_next[31:0] + 32'd1) : pair_next[31:0];

   assign div_zero = (op_b == 32'd0);
   assign div_ovf  = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

   assign data_resultRDY = (state == DONE);

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = ctrl_MULT ? MUL : DIV_RUN;
      end else begin
         case (state)
            MUL:     state_next = DONE;
            DIV_RUN: if (div_zero || div_ovf || count == 6'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         op_a           <= '0;
         op_b           <= '0;
         abs_b          <= '0;
         sign           <= 1'b0;
         pair           <= '0;
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else begin
         state <= state_next;
         if (start) begin
            op_a <= data_operandA;
            op_b <= data_operandB;
            if (!ctrl_MULT) begin
               abs_b <= abs_b_in;
               sign  <= data_operandA[31] ^ data_operandB[31];
               pair  <= {32'd0, abs_a_in};
               count <= '0;
            end
         end else begin
            case (state)
               MUL: begin
                  data_result    <= product[31:0];
                  data_exception <= mul_ovf;
               end
               DIV_RUN: begin
                  if (div_zero) begin
                     data_result    <= 32'd0;
                     data_exception <= 1'b1;
                  end else if (div_ovf) begin
                     data_result    <= 32'h8000_0000;
                     data_exception <= 1'b1;
                  end else begin
                     pair  <= pair_next;
                     count <= count + 6'd1;
                     if (count == 6'd31) begin
                        data_result    <= quotient;
                        data_exception <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - self-checking bench for multdiv_unit
// Directed and random operations checked against an arithmetic reference model.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   multdiv_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      logic   exc;
      p   = longint'($signed(a)) * longint'($signed(b));
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      return {exc, p[31:0]};
   endfunction

   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint q;
      if (b == 32'd0) return {1'b1, 32'd0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
      q = longint'($signed(a)) / longint'($signed(b));
      return {1'b0, q[31:0]};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic d, input string tag);
      logic [32:0] e;
      int          lat, n;
      e   = m ? ref_mul(a, b) : ref_div(a, b);
      lat = (m || b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 32;
      @(negedge clock);
      data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      n = 0;
      while (!data_resultRDY && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_result"}, data_result, e[31:0]);
      chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, e[32]});
      @(posedge clock); #1;
      chk({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
   endtask

   initial begin
      int pulses;
      logic [31:0] seen;
      logic [31:0] ra, rb;

      reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = '0; data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_result", data_result, 32'd0);
      chk("reset_exc", {31'd0, data_exception}, 32'd0);
      chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock); reset_n = 1'b1;

      run_op(32'd7, -32'sd6, 1'b1, 1'b0, "mul_basic");
      chk("mul_basic_const", data_result, 32'hFFFF_FFD6);
      run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, "mul_ovf");
      chk("mul_ovf_const", {31'd0, data_exception}, 32'd1);
      run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, "mul_min");
      run_op(-32'sd100, 32'd7, 1'b0, 1'b1, "div_basic");
      chk("div_basic_const", data_result, 32'hFFFF_FFF2);
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "div_neg1");
      run_op(32'd12345, 32'd0, 1'b0, 1'b1, "div_zero");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "div_ovf");
      run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, "div_min_by1");
      run_op(32'd9, 32'd11, 1'b1, 1'b1, "both_ctrl");

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? $urandom_range(0, 300) : $urandom;
         if (i % 2 == 0) rb = {{16{rb[15]}}, rb[15:0]};
         run_op(ra, rb, 1'b1, 1'b0, "rand_mul");
      end
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? $urandom_range(0, 20) - 32'd10 : $urandom;
         if (i % 5 == 1) rb = 32'd0;
         run_op(ra, rb, 1'b0, 1'b1, "rand_div");
      end

      // Divide aborted by a multiply ten cycles later
      @(negedge clock);
      data_operandA = 32'd1000; data_operandB = 32'd3; ctrl_DIV = 1'b1;
      @(posedge clock); #1; ctrl_DIV = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1;
      @(posedge clock); #1; ctrl_MULT = 1'b0;
      pulses = 0; seen = 32'hDEAD_BEEF;
      for (int i = 0; i < 40; i++) begin
         if (data_resultRDY) begin
            pulses++;
            seen = data_result;
         end
         @(posedge clock); #1;
      end
      chk("abort_pulses", 32'(pulses), 32'd1);
      chk("abort_result", seen, 32'd15);

      // Reset while a divide is at count 20
      @(negedge clock);
      data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
      @(posedge clock); #1; ctrl_DIV = 1'b0;
      repeat (20) @(posedge clock);
      @(negedge clock); reset_n = 1'b0;
      @(posedge clock); #1;
      chk("midreset_result", data_result, 32'd0);
      chk("midreset_exc", {31'd0, data_exception}, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (data_resultRDY) pulses++;
      end
      chk("midreset_no_rdy", 32'(pulses), 32'd0);
      chk("midreset_hold", data_result, 32'd0);
      run_op(32'hFFFF_FFFD, 32'd4, 1'b1, 1'b0, "post_reset_mul");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
